// File: rtl/connect_join.sv
`default_nettype none
// ============================================================================
//  Module   : connect_join
//  Purpose  : Merges CONNECT_NUM valid/ready token channels into one output
//             channel. One requester is granted per cycle and its token is
//             written, together with its channel index, into a 2-entry
//             output buffer that isolates the consumer's ready path.
//  Options  : CONNECT_JOIN_RR_EN defined   -> round-robin arbitration
//             CONNECT_JOIN_RR_EN undefined -> fixed priority (lowest index)
//  Revision : 1.0 - initial release
// ============================================================================
module connect_join #(
    parameter int DATA_WIDTH  = 32,
    parameter int CONNECT_NUM = 3,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CONNECT_NUM-1:0]            receive_valid,
    input  logic [DATA_WIDTH*CONNECT_NUM-1:0] receive_data,
    output logic [CONNECT_NUM-1:0]            receive_ready,
    output logic                              send_valid,
    output logic [DATA_WIDTH-1:0]             send_data,
    output logic [INDEX_WIDTH-1:0]            send_index,
    input  logic                              send_ready
);

    // One extra bit so that (start + offset) cannot overflow before the wrap
    localparam logic [INDEX_WIDTH:0]   C_NUM  = (INDEX_WIDTH+1)'(CONNECT_NUM);
    localparam logic [INDEX_WIDTH-1:0] C_LAST = INDEX_WIDTH'(CONNECT_NUM - 1);

    logic [DATA_WIDTH-1:0]  r_mem_data  [2];
    logic [INDEX_WIDTH-1:0] r_mem_index [2];
    logic                   r_head;
    logic                   r_tail;
    logic [1:0]             r_count;

    logic [INDEX_WIDTH-1:0] w_start;
    logic [INDEX_WIDTH:0]   w_cand;
    logic [INDEX_WIDTH-1:0] w_grant_index;
    logic                   w_found;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [DATA_WIDTH-1:0]  w_push_data;

`ifdef CONNECT_JOIN_RR_EN
    logic [INDEX_WIDTH-1:0] r_ptr;

    assign w_start = r_ptr;

    // Round-robin pointer: the next search starts just past the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_push) begin
            r_ptr <= (w_grant_index == C_LAST) ? '0 : w_grant_index + 1'b1;
        end
    end
`else
    // Fixed priority is a search that always starts at channel 0
    assign w_start = '0;
`endif

    // Buffer has room only when fewer than two tokens are held; reset forces
    // the grant low combinationally so nothing is accepted while in reset
    assign w_accept = (r_count != 2'd2) && rst_n;

    // Search valid channels starting at w_start, wrapping modulo CONNECT_NUM
    always_comb begin
        w_found       = 1'b0;
        w_grant_index = '0;
        w_cand        = '0;
        for (int k = 0; k < CONNECT_NUM; k++) begin
            w_cand = {1'b0, w_start} + (INDEX_WIDTH+1)'(k);
            if (w_cand >= C_NUM) begin
                w_cand = w_cand - C_NUM;
            end
            if (!w_found && receive_valid[w_cand[INDEX_WIDTH-1:0]]) begin
                w_found       = 1'b1;
                w_grant_index = w_cand[INDEX_WIDTH-1:0];
            end
        end
    end

    // One-hot grant at the selected channel, or all zero
    always_comb begin
        receive_ready = '0;
        if (w_accept && w_found) begin
            receive_ready[w_grant_index] = 1'b1;
        end
    end

    assign w_push      = w_accept && w_found;
    assign w_pop       = send_valid && send_ready;
    assign w_push_data = receive_data[DATA_WIDTH*w_grant_index +: DATA_WIDTH];

    // Outputs come straight from registered storage, never from receive_*
    assign send_valid = (r_count != 2'd0);
    assign send_data  = r_mem_data[r_head];
    assign send_index = r_mem_index[r_head];

    // Two-entry FIFO: write at tail on push, advance head on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_data[0]  <= '0;
            r_mem_data[1]  <= '0;
            r_mem_index[0] <= '0;
            r_mem_index[1] <= '0;
            r_head         <= 1'b0;
            r_tail         <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_data[r_tail]  <= w_push_data;
                r_mem_index[r_tail] <= w_grant_index;
                r_tail              <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_connect_join.sv
`default_nettype none
// ============================================================================
//  Module   : tb_connect_join
//  Purpose  : Self-checking bench for connect_join. A reference model of the
//             arbiter and buffer occupancy predicts grants and pushes expected
//             tokens into a scoreboard; a monitor compares the output head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_connect_join;

    localparam int DW = 32;
    localparam int N  = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    receive_valid;
    logic [DW*N-1:0] receive_data;
    logic [N-1:0]    receive_ready;
    logic            send_valid;
    logic [DW-1:0]   send_data;
    logic [IW-1:0]   send_index;
    logic            send_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    // Scoreboard of expected tokens {data, index} in output order
    logic [DW+IW-1:0] sb [$];
    // Reference model state: tokens held and round-robin start channel
    int m_count = 0;
    int m_ptr   = 0;

    int               g;
    int               c;
    logic [N-1:0]     exp_ready;
    logic             m_pop;
    logic [DW+IW-1:0] head_tok;
    logic [N-1:0]     held;
    logic [N-1:0]     nv;
    logic [DW*N-1:0]  nd;
    logic [N-1:0]     e;
    int               p0;

    connect_join #(
        .DATA_WIDTH  (DW),
        .CONNECT_NUM (N),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .receive_valid (receive_valid),
        .receive_data  (receive_data),
        .receive_ready (receive_ready),
        .send_valid    (send_valid),
        .send_data     (send_data),
        .send_index    (send_index),
        .send_ready    (send_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [DW*N-1:0] d, input logic sr);
        @(posedge clk);
        #1;
        receive_valid = v;
        receive_data  = d;
        send_ready    = sr;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive('0, receive_data, 1'b1);
        end
    endtask

    // Reference model: predict the grant, account occupancy, record pushes
    always @(negedge clk) begin
        if (rst_n) begin
            exp_ready = '0;
            g         = -1;
            if (m_count < 2) begin
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (g < 0 && receive_valid[c]) g = c;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("receive_ready", receive_ready, exp_ready);
            check("send_valid", send_valid, m_count != 0);
            m_pop = (m_count != 0) && send_ready;
            if (g >= 0) begin
                sb.push_back({receive_data[g*DW +: DW], IW'(g)});
`ifdef CONNECT_JOIN_RR_EN
                m_ptr = (g + 1) % N;
`endif
            end
            m_count = m_count + ((g >= 0) ? 1 : 0) - (m_pop ? 1 : 0);
        end
    end

    // Monitor: the presented head must equal the oldest expected token
    always @(negedge clk) begin
        if (rst_n && send_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: output valid with data %0h but no token expected", send_data);
            end else begin
                head_tok = sb[0];
                check("send_data", send_data, head_tok[DW+IW-1:IW]);
                check("send_index", send_index, head_tok[IW-1:0]);
                if (send_ready) begin
                    void'(sb.pop_front());
                    n_pops++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        receive_valid = '1;
        receive_data  = '0;
        send_ready    = 1'b0;
        held          = '0;

        // Reset state, with every channel requesting
        repeat (2) @(posedge clk);
        #1;
        check("rst_send_valid", send_valid, 0);
        check("rst_send_data", send_data, 0);
        check("rst_send_index", send_index, 0);
        check("rst_receive_ready", receive_ready, 0);
        @(posedge clk);
        #3;
        rst_n         = 1'b1;
        receive_valid = '0;

        // Contention: all three channels valid, consumer always ready
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, {32'hC2, 32'hC1, 32'hC0}, 1'b1);
            at_neg();
`ifdef CONNECT_JOIN_RR_EN
            e = 3'b001 << (i % 3);
`else
            e = 3'b001;
`endif
            check("contention_grant", receive_ready, e);
        end
        drive(3'b110, {32'hC2, 32'hC1, 32'hC0}, 1'b1);
        at_neg();
        check("contention_ch0_drop", receive_ready, 3'b010);
        drain(4);

        // Single channel: grant in cycle 0, output in cycle 1, empty in cycle 2
        drive(3'b010, {32'h0, 32'hA5, 32'h0}, 1'b1);
        at_neg();
        check("single_grant", receive_ready, 3'b010);
        drive(3'b000, '0, 1'b1);
        at_neg();
        check("single_valid", send_valid, 1);
        check("single_data", send_data, 32'hA5);
        check("single_index", send_index, 1);
        drive(3'b000, '0, 1'b1);
        at_neg();
        check("single_empty", send_valid, 0);

        // Backpressure fill: two tokens accepted, third held until room
        drive(3'b001, {64'h0, 32'h1}, 1'b0);
        at_neg();
        check("bp_grant1", receive_ready, 3'b001);
        drive(3'b001, {64'h0, 32'h2}, 1'b0);
        at_neg();
        check("bp_grant2", receive_ready, 3'b001);
        for (int i = 0; i < 2; i++) begin
            drive(3'b001, {64'h0, 32'h3}, 1'b0);
            at_neg();
            check("bp_full_no_grant", receive_ready, 3'b000);
            check("bp_head_hold", send_data, 32'h1);
        end
        drive(3'b001, {64'h0, 32'h3}, 1'b1);
        at_neg();
        check("full_pop_no_grant", receive_ready, 3'b000);
        drive(3'b001, {64'h0, 32'h3}, 1'b1);
        at_neg();
        check("bp_grant3", receive_ready, 3'b001);
        drain(4);

        // Throughput: steady stream on channel 0 with consumer ready
        drive(3'b001, {64'h0, 32'h77}, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        p0 = n_pops;
        repeat (8) @(negedge clk);
        #1;
        check("throughput_pops", n_pops - p0, 8);
        drain(4);

        // Asynchronous reset with the buffer full (ch1 tokens move RR pointer to 2)
        drive(3'b010, {32'h0, 32'h11, 32'h0}, 1'b0);
        drive(3'b010, {32'h0, 32'h22, 32'h0}, 1'b0);
        drive(3'b000, '0, 1'b0);
        #2;
        rst_n         = 1'b0;
        receive_valid = 3'b111;
        #1;
        check("async_send_valid", send_valid, 0);
        check("async_receive_ready", receive_ready, 0);
        sb.delete();
        m_count = 0;
        m_ptr   = 0;
        @(posedge clk);
        #3;
        receive_valid = 3'b110;
        receive_data  = {32'h44, 32'h33, 32'h0};
        send_ready    = 1'b1;
        rst_n         = 1'b1;
        at_neg();
        check("post_reset_ptr0", receive_ready, 3'b010);
        drive(3'b100, {32'h44, 32'h33, 32'h0}, 1'b1);
        at_neg();
        check("post_reset_ch2", receive_ready, 3'b100);
        drain(4);

        // Randomized traffic; ungranted channels hold their valid and data
        held = '0;
        for (int i = 0; i < 400; i++) begin
            nv = held;
            nd = receive_data;
            for (int ch = 0; ch < N; ch++) begin
                if (!held[ch]) begin
                    nv[ch]            = 1'($urandom_range(0, 1));
                    nd[ch*DW +: DW]   = $urandom;
                end
            end
            drive(nv, nd, 1'($urandom_range(0, 1)));
            at_neg();
            held = receive_valid & ~receive_ready;
        end

        // Bounded drain: every expected token must have come out
        for (int i = 0; i < 20; i++) begin
            if (sb.size() != 0 || send_valid) begin
                drive('0, receive_data, 1'b1);
                at_neg();
            end
        end
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/connect_join.md
Name: connect_join

Overview:
- Downstream counterpart of the fork stage: merges CONNECT_NUM valid/ready token channels into one output channel.
- Per-cycle arbitration selects one requester; the winner's token is written into a 2-entry output buffer, which breaks the combinational ready path toward the consumer.
- Sits at the input of every dataflow node that takes tokens from several producers.

Parameters:
- DATA_WIDTH, 32, token width in bits.
- CONNECT_NUM, 3, number of input channels; minimum 1.
- INDEX_WIDTH, 2, width of SEND_INDEX; must satisfy 2**INDEX_WIDTH >= CONNECT_NUM.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RECEIVE_VALID  input  CONNECT_NUM  per-channel token valid.
- RECEIVE_DATA  input  DATA_WIDTH*CONNECT_NUM  channel i occupies bits [DATA_WIDTH*i +: DATA_WIDTH].
- RECEIVE_READY  output  CONNECT_NUM  one-hot-or-zero grant; channel i transfers when VALID[i] && READY[i].
- SEND_VALID  output  1  buffer head holds a token.
- SEND_DATA  output  DATA_WIDTH  head token.
- SEND_INDEX  output  INDEX_WIDTH  source channel of head token.
- SEND_READY  input  1  consumer accepts head.

Behaviour:
- Clock and reset are fixed: one clock CLK; reset RST_N is asynchronous and active-low.
- Reset values: buffer count = 0, SEND_VALID = 0, SEND_DATA = 0, SEND_INDEX = 0, arbitration pointer = 0.
- RECEIVE_READY is combinational: all zero while RST_N is low.
- Buffer structure: 2-entry FIFO holding {data, index}, with head pointer, tail pointer and count (0..2).
  - SEND_VALID = (count != 0).
  - SEND_DATA and SEND_INDEX are driven from registered head storage; there is no combinational path from RECEIVE_* to SEND_*.
- Accept condition: count < 2. The decision ignores SEND_READY, so there is no ready pass-through.
- Grant generation:
  - If accept and any RECEIVE_VALID bit is set, exactly one RECEIVE_READY bit is set, at the chosen valid channel. Otherwise all bits are 0.
  - Grant depends only on RECEIVE_VALID, count and the pointer; it never depends on RECEIVE_DATA.
- Push: a handshake on channel g writes {RECEIVE_DATA[g], g} at tail, advances tail, and increments count.
- Pop: SEND_VALID && SEND_READY advances head and decrements count.
- Simultaneous push and pop:
  - count 1 → stays 1, new token becomes head next cycle.
  - count 2 → no push allowed; pop only, count becomes 1.
- Latency: a token granted in cycle n appears on SEND_* in cycle n+1 if the buffer was empty.
- Throughput: 1 token/cycle sustained while SEND_READY = 1.
- Ordering: output order equals grant order. A token is never dropped or duplicated.
- Valid stability: a channel whose VALID is high and not granted is expected to hold VALID and DATA. The block does not check this.
- Backpressure: SEND_VALID stays high and SEND_DATA/SEND_INDEX stay stable until SEND_READY is high.
- Wrap-around: head and tail are 1-bit pointers toggling 0↔1.
- Reset asserted mid-operation: buffered tokens are discarded and the pointer returns to 0 immediately, without waiting for a clock edge.
- CONNECT_NUM = 1: grant = RECEIVE_VALID[0] && accept; SEND_INDEX is always 0.

Optional Feature:
- Macro CONNECT_JOIN_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at the pointer and wraps modulo CONNECT_NUM.
  - After a push from channel g, pointer = (g+1) mod CONNECT_NUM.
  - The pointer is unchanged when no push occurs.
  - Guarantees no channel waits more than CONNECT_NUM grants.
- Undefined: fixed priority, lowest valid index wins; the pointer register is not instantiated.

Test Plan:
- Reset / single channel: reset, then RECEIVE_VALID=3'b010, DATA ch1=0xA5, SEND_READY=1 → READY=3'b010 in cycle 0; SEND_VALID=1, SEND_DATA=0xA5, SEND_INDEX=1 in cycle 1; SEND_VALID=0 in cycle 2.
- Backpressure fill: SEND_READY=0, ch0 streams 0x1, 0x2, 0x3 → first two accepted; READY[0]=0 while count=2; SEND_DATA holds 0x1. Then SEND_READY=1 → outputs 0x1, 0x2, 0x3 in order, no loss.
- Contention with RR_EN: all three channels valid continuously, SEND_READY=1 → grant sequence 0,1,2,0,1,2; SEND_INDEX follows one cycle later.
- Contention without RR_EN: same stimulus → channel 0 granted every cycle; channels 1 and 2 starved until VALID[0] drops, then ch1 is granted.
- Simultaneous push/pop at count 1: steady stream at 1 token/cycle → count stays 1 and a throughput of 1/cycle is measured. At count 2 with SEND_READY=1 → no grant that cycle, count goes to 1.
- Async reset mid-stream: assert RST_N=0 between clock edges with count=2 → SEND_VALID=0 and RECEIVE_READY=0 immediately. After release, a new token on ch2 is accepted normally and the pointer restarts at 0.
